// File: rtl/load_store_unit.sv
// Load/store stage: sequences one single-data-transfer access to synchronous data memory
// and returns the loaded value and updated base as register-file write requests.
module load_store_unit (
  input  logic        clk,
  input  logic        nreset,
  input  logic        start,
  input  logic        cond_pass,
  input  logic        load_store,
  input  logic        byte_or_word,
  input  logic        pre_post,
  input  logic        write_back,
  input  logic [31:0] alu_result,
  input  logic [31:0] base_data,
  input  logic [31:0] store_data,
  input  logic [3:0]  rd,
  input  logic [3:0]  rn,
  output logic        mem_en,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        busy,
  output logic        done,
  output logic        wb_en,
  output logic [3:0]  wb_addr,
  output logic [31:0] wb_data,
  output logic        base_wb_en,
  output logic [3:0]  base_wb_addr,
  output logic [31:0] base_wb_data,
  output logic        wb_pc
);

  localparam int unsigned DataW = 32;
  localparam int unsigned RegW  = 4;
  localparam int unsigned LaneW = 4;

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, DONE} stateT;

  stateT state, stateNext;

  // Captured copy of the request; live inputs are only trusted on the start edge.
  logic             opLoad;
  logic             opByte;
  logic             opBaseWb;
  logic [DataW-1:0] opEa;
  logic [DataW-1:0] opAlu;
  logic [RegW-1:0]  opRd;
  logic [RegW-1:0]  opRn;

  logic [DataW-1:0] eaIn;
  logic             memEnNxt;
  logic             memWeNxt;
  logic [LaneW-1:0] memBeNxt;
  logic [DataW-1:0] memAddrNxt;
  logic [DataW-1:0] memWdataNxt;
  logic             wbEnNxt;
  logic             baseWbEnNxt;
  logic             executing;
  logic [4:0]       laneShift;
  logic [DataW-1:0] rotWord;
  logic [DataW-1:0] loadValue;

  always_ff @(posedge clk) begin
    if (nreset) state <= IDLE;
    else        state <= stateNext;
  end

  // Next state plus the values the registered outputs take on the coming edge.
  always_comb begin
    stateNext   = state;
    eaIn        = pre_post ? alu_result : base_data;
    memEnNxt    = 1'b0;
    memWeNxt    = 1'b0;
    memBeNxt    = '0;
    memAddrNxt  = '0;
    memWdataNxt = '0;
    executing   = 1'b0;
    wbEnNxt     = 1'b0;
    baseWbEnNxt = 1'b0;
    laneShift   = {opEa[1:0], 3'b000};
    rotWord     = DataW'({mem_rdata, mem_rdata} >> laneShift);
    loadValue   = opByte ? {24'b0, rotWord[7:0]} : rotWord;
    case (state)
      IDLE: begin
        if (start) begin
          stateNext = cond_pass ? ACCESS : DONE;
          if (cond_pass) begin
            memEnNxt   = 1'b1;
            memWeNxt   = ~load_store;
            memAddrNxt = {eaIn[31:2], 2'b00};
            memBeNxt   = byte_or_word ? LaneW'(4'b0001 << eaIn[1:0]) : 4'b1111;
            if (!load_store)
              memWdataNxt = byte_or_word ? {4{store_data[7:0]}} : store_data;
          end
        end
      end
      ACCESS: begin
        stateNext = opLoad ? WAIT : DONE;
        executing = ~opLoad;
      end
      WAIT: begin
        stateNext = DONE;
        executing = 1'b1;
        wbEnNxt   = 1'b1;
      end
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
    baseWbEnNxt = executing & opBaseWb;
  end

  always_ff @(posedge clk) begin
    if (nreset) begin
      opLoad   <= 1'b0;
      opByte   <= 1'b0;
      opBaseWb <= 1'b0;
      opEa     <= '0;
      opAlu    <= '0;
      opRd     <= '0;
      opRn     <= '0;
    end else if (state == IDLE && start) begin
      opLoad   <= load_store;
      opByte   <= byte_or_word;
      // A load into the base register suppresses the base update.
      opBaseWb <= (~pre_post | write_back) & ~(load_store & (rd == rn));
      opEa     <= eaIn;
      opAlu    <= alu_result;
      opRd     <= rd;
      opRn     <= rn;
    end
  end

  always_ff @(posedge clk) begin
    if (nreset) begin
      mem_en       <= 1'b0;
      mem_we       <= 1'b0;
      mem_be       <= '0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      wb_en        <= 1'b0;
      wb_addr      <= '0;
      wb_data      <= '0;
      wb_pc        <= 1'b0;
      base_wb_en   <= 1'b0;
      base_wb_addr <= '0;
      base_wb_data <= '0;
    end else begin
      mem_en     <= memEnNxt;
      mem_we     <= memWeNxt;
      mem_be     <= memBeNxt;
      mem_addr   <= memAddrNxt;
      mem_wdata  <= memWdataNxt;
      busy       <= (stateNext != IDLE);
      done       <= (stateNext == DONE);
      wb_en      <= wbEnNxt;
      wb_pc      <= wbEnNxt & (opRd == 4'hF);
      base_wb_en <= baseWbEnNxt;
      if (wbEnNxt) begin
        wb_addr <= opRd;
        wb_data <= loadValue;
      end
      if (executing) begin
        base_wb_addr <= opRn;
        base_wb_data <= opAlu;
      end
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed cases plus random transfers
// compared cycle by cycle against a transaction-level reference model.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        nreset = 1'b1;
  logic        start = 1'b0;
  logic        cond_pass = 1'b0;
  logic        load_store = 1'b0;
  logic        byte_or_word = 1'b0;
  logic        pre_post = 1'b0;
  logic        write_back = 1'b0;
  logic [31:0] alu_result = '0;
  logic [31:0] base_data = '0;
  logic [31:0] store_data = '0;
  logic [3:0]  rd = '0;
  logic [3:0]  rn = '0;
  logic        mem_en;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        busy;
  logic        done;
  logic        wb_en;
  logic [3:0]  wb_addr;
  logic [31:0] wb_data;
  logic        base_wb_en;
  logic [3:0]  base_wb_addr;
  logic [31:0] base_wb_data;
  logic        wb_pc;

  int nCmp = 0;
  int nErr = 0;
  logic        useOv = 1'b0;
  logic [31:0] ovData = '0;

  load_store_unit dut (
    .clk(clk), .nreset(nreset), .start(start), .cond_pass(cond_pass),
    .load_store(load_store), .byte_or_word(byte_or_word), .pre_post(pre_post),
    .write_back(write_back), .alu_result(alu_result), .base_data(base_data),
    .store_data(store_data), .rd(rd), .rn(rn), .mem_en(mem_en), .mem_we(mem_we),
    .mem_be(mem_be), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .busy(busy), .done(done), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .base_wb_en(base_wb_en), .base_wb_addr(base_wb_addr), .base_wb_data(base_wb_data),
    .wb_pc(wb_pc)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction

  // Synchronous read-only memory: data appears the cycle after a read strobe.
  always @(posedge clk)
    if (mem_en && !mem_we) mem_rdata <= useOv ? ovData : memf(mem_addr);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nCmp++;
    assert (obs === exp) else begin
      nErr++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic scramble(input bit noise);
    start        = noise ? 1'($urandom_range(0, 1)) : 1'b0;
    cond_pass    = 1'($urandom_range(0, 1));
    load_store   = 1'($urandom_range(0, 1));
    byte_or_word = 1'($urandom_range(0, 1));
    pre_post     = 1'($urandom_range(0, 1));
    write_back   = 1'($urandom_range(0, 1));
    alu_result   = $urandom;
    base_data    = $urandom;
    store_data   = $urandom;
    rd           = 4'($urandom_range(0, 15));
    rn           = 4'($urandom_range(0, 15));
  endtask

  task automatic doOp(input bit c, input bit ld, input bit by, input bit pre, input bit wbit,
                      input logic [31:0] alu, input logic [31:0] base, input logic [31:0] sd,
                      input logic [3:0] rdI, input logic [3:0] rnI, input bit noise);
    logic [31:0] ea, addr, rdat, expLoad, expWdata;
    logic [3:0]  expBe;
    int          lat, sh;
    bit          expWb, expBase;
    ea    = pre ? alu : base;
    addr  = {ea[31:2], 2'b00};
    rdat  = useOv ? ovData : memf(addr);
    sh    = 8 * int'(ea[1:0]);
    if (by) expLoad = (rdat >> sh) & 32'hFF;
    else    expLoad = (sh == 0) ? rdat : ((rdat >> sh) | (rdat << (32 - sh)));
    expBe    = by ? (4'b0001 << ea[1:0]) : 4'b1111;
    expWdata = by ? {4{sd[7:0]}} : sd;
    lat      = !c ? 1 : (ld ? 3 : 2);
    expWb    = c && ld;
    expBase  = c && (!pre || wbit) && !(ld && rdI == rnI);

    cond_pass = c; load_store = ld; byte_or_word = by; pre_post = pre; write_back = wbit;
    alu_result = alu; base_data = base; store_data = sd; rd = rdI; rn = rnI;
    start = 1'b1;
    @(posedge clk);
    #1 scramble(noise);
    for (int k = 1; k <= lat; k++) begin
      @(negedge clk);
      chk("busy", busy, 1);
      chk("done", done, (k == lat));
      chk("mem_en", mem_en, (c && k == 1));
      chk("mem_we", mem_we, (c && k == 1 && !ld));
      if (c && k == 1) begin
        chk("mem_addr", mem_addr, addr);
        if (!ld) begin
          chk("mem_be", mem_be, expBe);
          chk("mem_wdata", mem_wdata, expWdata);
        end
      end
      if (k == lat) begin
        chk("wb_en", wb_en, expWb);
        chk("base_wb_en", base_wb_en, expBase);
        chk("wb_pc", wb_pc, (expWb && rdI == 4'hF));
        if (expWb) begin
          chk("wb_addr", wb_addr, rdI);
          chk("wb_data", wb_data, expLoad);
        end
        if (expBase) begin
          chk("base_wb_addr", base_wb_addr, rnI);
          chk("base_wb_data", base_wb_data, alu);
        end
      end else begin
        chk("wb_en_early", wb_en, 0);
        chk("base_wb_en_early", base_wb_en, 0);
      end
      scramble(noise);
    end
    @(negedge clk);
    start = 1'b0;
    chk("busy_after", busy, 0);
    chk("done_after", done, 0);
    chk("mem_en_after", mem_en, 0);
  endtask

  task automatic chkAllZero(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_mem_en"}, mem_en, 0);
    chk({tag, "_mem_we"}, mem_we, 0);
    chk({tag, "_mem_be"}, mem_be, 0);
    chk({tag, "_mem_addr"}, mem_addr, 0);
    chk({tag, "_mem_wdata"}, mem_wdata, 0);
    chk({tag, "_wb_en"}, wb_en, 0);
    chk({tag, "_wb_addr"}, wb_addr, 0);
    chk({tag, "_wb_data"}, wb_data, 0);
    chk({tag, "_wb_pc"}, wb_pc, 0);
    chk({tag, "_base_wb_en"}, base_wb_en, 0);
    chk({tag, "_base_wb_addr"}, base_wb_addr, 0);
    chk({tag, "_base_wb_data"}, base_wb_data, 0);
  endtask

  initial begin
    nreset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chkAllZero("reset");
    nreset = 1'b0;
    @(negedge clk);

    doOp(1, 0, 0, 1, 0, 32'h104, 32'h100, 32'hDEADBEEF, 4'd1, 4'd2, 0);
    useOv = 1'b1; ovData = 32'hAABBCCDD;
    doOp(1, 1, 1, 0, 0, 32'h207, 32'h203, 32'h0, 4'd2, 4'd3, 0);
    chk("byte_load_hold", wb_data, 32'h000000AA);
    chk("byte_load_base", base_wb_data, 32'h00000207);
    ovData = 32'h11223344;
    doOp(1, 1, 0, 1, 0, 32'h101, 32'h0FC, 32'h0, 4'd4, 4'd6, 0);
    chk("unaligned_word", wb_data, 32'h44112233);
    doOp(0, 1, 0, 1, 1, 32'h300, 32'h2F0, 32'h0, 4'd7, 4'd8, 0);
    doOp(1, 1, 0, 1, 1, 32'h400, 32'h3F0, 32'h0, 4'd5, 4'd5, 0);
    doOp(1, 1, 0, 0, 0, 32'h510, 32'h500, 32'h0, 4'd15, 4'd9, 1);
    doOp(1, 0, 1, 1, 1, 32'h603, 32'h600, 32'h123456C3, 4'd3, 4'd10, 1);
    useOv = 1'b0;

    for (int i = 0; i < 40; i++)
      doOp(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom, $urandom, $urandom,
           4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1);

    // Reset during WAIT discards the pending write-back.
    cond_pass = 1; load_store = 1; byte_or_word = 0; pre_post = 1; write_back = 1;
    alu_result = 32'h700; base_data = 32'h6F0; rd = 4'd1; rn = 4'd2;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    nreset = 1'b1;
    @(negedge clk);
    chkAllZero("midreset");
    nreset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("post_reset_done", done, 0);
      chk("post_reset_busy", busy, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end

endmodule
